// File: rtl/mem_i_d_arbiter.sv
// mem_i_d_arbiter: shares one single-port unified BRAM between the CPU fetch
// port (I) and the load/store port (D). One access is issued per cycle and
// its response returns exactly one cycle later.
// Build option: define MEMARB_RR_EN for round-robin contest resolution;
// otherwise D has fixed priority with a starvation override for I.
module mem_i_d_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rdy,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rdy,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d_in,
  input  logic [DATA_W-1:0] mem_d_out
);

  logic              contest;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic              rsp_v_reg;
  logic              rsp_port_reg;   // 1 = response belongs to I, 0 = D
  logic              rsp_we_reg;
  logic [DATA_W-1:0] i_hold_reg;
  logic [DATA_W-1:0] d_hold_reg;

  assign contest = i_req & d_req;

`ifdef MEMARB_RR_EN
  // 0 = D wins the next contest, 1 = I wins the next contest
  logic rr_ptr_reg;

  // Grant selection: contested cycles go to the port rr_ptr favours
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (contest) begin
        i_gnt = rr_ptr_reg;
        d_gnt = ~rr_ptr_reg;
      end else begin
        i_gnt = i_req;
        d_gnt = d_req;
      end
    end
  end

  // Flip the preference after every contested grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg <= 1'b0;
    end else if (contest) begin
      rr_ptr_reg <= ~rr_ptr_reg;
    end
  end
`else
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
  logic [7:0] starve_cnt_reg;

  // Grant selection: D wins contests unless I has waited STARVE_MAX cycles
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (contest) begin
        i_gnt = (starve_cnt_reg == STARVE_LIM);
        d_gnt = (starve_cnt_reg != STARVE_LIM);
      end else begin
        i_gnt = i_req;
        d_gnt = d_req;
      end
    end
  end

  // Count consecutive cycles I is kept waiting, saturating at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_reg <= 8'd0;
    end else if (!i_req || i_gnt) begin
      starve_cnt_reg <= 8'd0;
    end else if (starve_cnt_reg != STARVE_LIM) begin
      starve_cnt_reg <= starve_cnt_reg + 8'd1;
    end
  end
`endif

  // Idle cycles replay the last address so the BRAM output stays stable
  assign mem_addr = i_gnt ? i_addr : (d_gnt ? d_addr : mem_addr_reg);
  assign mem_w_en = d_gnt & d_we;
  assign mem_d_in = d_wdata;

  // Remember the last issued address and capture the response tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_reg <= '0;
      rsp_v_reg    <= 1'b0;
      rsp_port_reg <= 1'b0;
      rsp_we_reg   <= 1'b0;
    end else begin
      if (i_gnt || d_gnt) begin
        mem_addr_reg <= mem_addr;
      end
      rsp_v_reg    <= i_gnt | d_gnt;
      rsp_port_reg <= i_gnt;
      rsp_we_reg   <= d_gnt & d_we;
    end
  end

  assign i_rdy = rsp_v_reg & rsp_port_reg;
  assign d_rdy = rsp_v_reg & ~rsp_port_reg;

  // Hold the most recent read data of each port between responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_hold_reg <= '0;
      d_hold_reg <= '0;
    end else begin
      if (i_rdy) begin
        i_hold_reg <= mem_d_out;
      end
      if (d_rdy && !rsp_we_reg) begin
        d_hold_reg <= mem_d_out;
      end
    end
  end

  // Read data passes straight through in the rdy cycle of a read
  assign i_rdata = i_rdy ? mem_d_out : i_hold_reg;
  assign d_rdata = (d_rdy && !rsp_we_reg) ? mem_d_out : d_hold_reg;

endmodule

// File: tb/tb_mem_i_d_arbiter.sv
// Directed bench for mem_i_d_arbiter with a behavioural registered-output BRAM.
module tb_mem_i_d_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [12:0] i_addr;
  logic        i_gnt;
  logic        i_rdy;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [12:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rdy;
  logic [31:0] d_rdata;
  logic        mem_w_en;
  logic [12:0] mem_addr;
  logic [31:0] mem_d_in;
  logic [31:0] mem_d_out;
  logic        preload;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_i_d_arbiter #(.ADDR_W(13), .DATA_W(32), .STARVE_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rdy(i_rdy), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdy(d_rdy), .d_rdata(d_rdata),
    .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_d_in(mem_d_in), .mem_d_out(mem_d_out)
  );

  // BRAM model: write-or-read per edge, output register updates only on reads
  logic [31:0] mem [0:8191];
  always @(posedge clk) begin
    if (preload) begin
      mem[5]  <= 32'h1234_5678;
      mem[40] <= 32'hA0A0_A0A0;
      mem[41] <= 32'h4141_4141;
    end else if (mem_w_en) begin
      mem[mem_addr] <= mem_d_in;
    end else begin
      mem_d_out <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_i, prev_i, prev_d;
    rst = 1'b1; preload = 1'b1;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    tick;
    preload = 1'b0;
    // Reset: requests present but no grants, everything quiet
    i_req = 1; d_req = 1; d_we = 1; i_addr = 7; d_addr = 8;
    #1;
    check("rst_i_gnt", 32'(i_gnt), 32'd0);
    check("rst_d_gnt", 32'(d_gnt), 32'd0);
    check("rst_w_en", 32'(mem_w_en), 32'd0);
    check("rst_rdy", {30'd0, i_rdy, d_rdy}, 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    i_req = 0; d_req = 0; d_we = 0;
    tick;
    rst = 1'b0;
    tick;

    // Test 1: lone fetch
    i_req = 1; i_addr = 5;
    #1;
    check("t1_i_gnt", 32'(i_gnt), 32'd1);
    check("t1_d_gnt", 32'(d_gnt), 32'd0);
    check("t1_addr", 32'(mem_addr), 32'd5);
    tick;
    i_req = 0;
    #1;
    check("t1_i_rdy", 32'(i_rdy), 32'd1);
    check("t1_i_rdata", i_rdata, 32'h1234_5678);
    tick;
    check("t1_i_rdy_off", 32'(i_rdy), 32'd0);
    check("t1_i_hold", i_rdata, 32'h1234_5678);
    check("t1_addr_hold", 32'(mem_addr), 32'd5);

    // Test 2: write then read-after-write of the same address
    d_req = 1; d_we = 1; d_addr = 9; d_wdata = 32'hDEAD_BEEF;
    #1;
    check("t2_d_gnt", 32'(d_gnt), 32'd1);
    check("t2_w_en", 32'(mem_w_en), 32'd1);
    check("t2_addr", 32'(mem_addr), 32'd9);
    tick;
    d_we = 0;
    #1;
    check("t2_wr_rdy", 32'(d_rdy), 32'd1);
    check("t2_rd_w_en", 32'(mem_w_en), 32'd0);
    check("t2_rd_gnt", 32'(d_gnt), 32'd1);
    check("t2_wr_rdata", d_rdata, 32'd0);
    tick;
    d_req = 0;
    #1;
    check("t2_rd_rdy", 32'(d_rdy), 32'd1);
    check("t2_rd_rdata", d_rdata, 32'hDEAD_BEEF);
    check("t2_i_hold", i_rdata, 32'h1234_5678);

    // Test 6: write followed by an idle cycle
    d_req = 1; d_we = 1; d_addr = 20; d_wdata = 32'h0000_0055;
    #1;
    check("t6_addr", 32'(mem_addr), 32'd20);
    tick;
    d_req = 0; d_we = 0;
    #1;
    check("t6_wr_rdy", 32'(d_rdy), 32'd1);
    check("t6_wr_rdata", d_rdata, 32'hDEAD_BEEF);
    check("t6_idle_w_en", 32'(mem_w_en), 32'd0);
    check("t6_idle_addr", 32'(mem_addr), 32'd20);
    tick;
    check("t6_rdy_off", {30'd0, i_rdy, d_rdy}, 32'd0);
    check("t6_d_hold", d_rdata, 32'hDEAD_BEEF);
    check("t6_i_hold", i_rdata, 32'h1234_5678);
    check("t6_addr_hold", 32'(mem_addr), 32'd20);

    // Test 3/4: both ports requesting continuously
    i_addr = 40; d_addr = 41; d_we = 0; i_req = 1; d_req = 1;
    prev_i = 0; prev_d = 0;
    for (int c = 0; c < 18; c++) begin
      #1;
`ifdef MEMARB_RR_EN
      exp_i = (c % 2) == 1;
`else
      exp_i = (c % 9) == 8;
`endif
      check($sformatf("t3_i_gnt_c%0d", c), 32'(i_gnt), 32'(exp_i));
      check($sformatf("t3_d_gnt_c%0d", c), 32'(d_gnt), 32'(!exp_i));
      check($sformatf("t3_rdy_c%0d", c), {30'd0, i_rdy, d_rdy}, {30'd0, prev_i, prev_d});
      if (prev_i) check($sformatf("t3_i_rdata_c%0d", c), i_rdata, 32'hA0A0_A0A0);
      if (prev_d) check($sformatf("t3_d_rdata_c%0d", c), d_rdata, 32'h4141_4141);
      prev_i = exp_i;
      prev_d = !exp_i;
      @(posedge clk);
    end
    #1;
    i_req = 0; d_req = 0;
    #1;
    check("t3_last_rdy", {30'd0, i_rdy, d_rdy}, {30'd0, prev_i, prev_d});
    tick;

    // Test 5: reset asserted at the edge after an I grant
    i_req = 1; i_addr = 5;
    #1;
    check("t5_i_gnt", 32'(i_gnt), 32'd1);
    @(posedge clk);
    rst = 1'b1;
    i_req = 0;
    #1;
    check("t5_i_rdy", 32'(i_rdy), 32'd0);
    check("t5_outs", {i_gnt, d_gnt, i_rdy, d_rdy, mem_w_en, 14'd0, mem_addr}, 32'd0);
    check("t5_i_rdata", i_rdata, 32'd0);
    check("t5_d_rdata", d_rdata, 32'd0);
    tick;
    rst = 1'b0;
    tick;
    check("t5_post_rdy", {30'd0, i_rdy, d_rdy}, 32'd0);
    i_req = 1; i_addr = 5;
    #1;
    check("t5_re_gnt", 32'(i_gnt), 32'd1);
    tick;
    i_req = 0;
    #1;
    check("t5_re_rdy", 32'(i_rdy), 32'd1);
    check("t5_re_rdata", i_rdata, 32'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
